// File: rtl/rbt_s_parser_sync_if.sv
// AXI-Stream payload bundle used on both sides of the parser/metadata rejoin block.
interface rbt_s_parser_sync_if #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH = 64
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rbt_s_parser_sync.sv
// Rejoins parser payload with its delayed metadata: queues metadata, stalls payload until it
// arrives, then forwards or discards the packet. Stats compiled only with RBT_S_SYNC_STATS_EN.
module rbt_s_parser_sync #(
  parameter int unsigned DATA_WIDTH         = 512,
  parameter int unsigned KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH         = 64,
  parameter int unsigned PKT_METADATA_WIDTH = 274,
  parameter int unsigned META_FIFO_DEPTH    = 16,
  parameter int unsigned DROP_BIT_INDEX     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  rbt_s_parser_sync_if.slave            s_axis,
  input  logic                          s_meta_valid,
  output logic                          s_meta_ready,
  input  logic [PKT_METADATA_WIDTH-1:0] s_meta_info,
  rbt_s_parser_sync_if.master           m_axis,
  output logic                          m_axis_tfirst,
  output logic [PKT_METADATA_WIDTH-1:0] m_axis_tmeta,
  output logic [31:0]                   stat_pkt_pass,
  output logic [31:0]                   stat_pkt_drop,
  output logic                          stat_meta_ovf
);

  localparam int unsigned AW = $clog2(META_FIFO_DEPTH);

  if (KEEP_WIDTH * 8 != DATA_WIDTH) begin : g_keep_chk
    $error("KEEP_WIDTH*8 must equal DATA_WIDTH");
  end
  if (META_FIFO_DEPTH < 2 || (META_FIFO_DEPTH & (META_FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("META_FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (DROP_BIT_INDEX >= PKT_METADATA_WIDTH) begin : g_drop_chk
    $error("DROP_BIT_INDEX out of range");
  end

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e state_q, state_d;

  logic [PKT_METADATA_WIDTH-1:0] mem_q [META_FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [AW:0]                   count_q;
  logic [PKT_METADATA_WIDTH-1:0] head;
  logic [PKT_METADATA_WIDTH-1:0] meta_q;
  logic                          first_q;
  logic                          full, empty, push, pop;
  logic                          s_ready, m_valid, tfirst, accept, pkt_end;

  // Metadata FIFO; full is judged on the registered count, so a pop never frees a slot early.
  assign full         = (count_q == (AW + 1)'(META_FIFO_DEPTH));
  assign empty        = (count_q == '0);
  assign s_meta_ready = !full;
  assign push         = s_meta_valid && !full;
  assign pop          = (state_q == StIdle) && !empty && s_axis.tvalid;
  assign head         = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_meta_info;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign accept  = s_axis.tvalid && s_ready;
  assign pkt_end = accept && s_axis.tlast;

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:         if (pop) state_d = head[DROP_BIT_INDEX] ? StDrop : StPass;
      StPass, StDrop: if (pkt_end) state_d = StIdle;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    tfirst  = 1'b0;
    unique case (state_q)
      StPass: begin
        m_valid = s_axis.tvalid;
        s_ready = m_axis.tready;
        tfirst  = first_q;
      end
      StDrop:  s_ready = 1'b1;
      default: ;
    endcase
  end

  // Metadata stays registered through IDLE so the sideband is stable until the next pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      first_q <= 1'b0;
    end else if (pop) begin
      meta_q  <= head;
      first_q <= 1'b1;
    end else if (accept) begin
      first_q <= 1'b0;
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis_tfirst = tfirst;
  assign m_axis_tmeta  = meta_q;

`ifdef RBT_S_SYNC_STATS_EN
  logic [31:0] pass_q, drop_q;
  logic        ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (pkt_end && state_q == StPass) pass_q <= pass_q + 32'd1;
      if (pkt_end && state_q == StDrop) drop_q <= drop_q + 32'd1;
      if (s_meta_valid && full)         ovf_q  <= 1'b1;
    end
  end

  assign stat_pkt_pass = pass_q;
  assign stat_pkt_drop = drop_q;
  assign stat_meta_ovf = ovf_q;
`else
  assign stat_pkt_pass = '0;
  assign stat_pkt_drop = '0;
  assign stat_meta_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_rbt_s_parser_sync.sv
// Self-checking bench for rbt_s_parser_sync: directed scenarios plus randomized packets
// compared against a packet-level reference model.
module tb_rbt_s_parser_sync;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int UW    = 16;
  localparam int MW    = 40;
  localparam int DEPTH = 16;

`ifdef RBT_S_SYNC_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rbt_s_parser_sync_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) s_if ();
  rbt_s_parser_sync_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) m_if ();

  logic          s_meta_valid, s_meta_ready;
  logic [MW-1:0] s_meta_info;
  logic          m_tfirst;
  logic [MW-1:0] m_tmeta;
  logic [31:0]   st_pass, st_drop;
  logic          st_ovf;

  rbt_s_parser_sync #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .PKT_METADATA_WIDTH(MW),
    .META_FIFO_DEPTH(DEPTH), .DROP_BIT_INDEX(0)
  ) dut (
    .clk(clk), .rst(rst), .s_axis(s_if),
    .s_meta_valid(s_meta_valid), .s_meta_ready(s_meta_ready), .s_meta_info(s_meta_info),
    .m_axis(m_if), .m_axis_tfirst(m_tfirst), .m_axis_tmeta(m_tmeta),
    .stat_pkt_pass(st_pass), .stat_pkt_drop(st_drop), .stat_meta_ovf(st_ovf)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic          first;
    logic [MW-1:0] meta;
  } beat_t;

  beat_t         exp_q[$], got_q[$], mon_b;
  logic [MW-1:0] meta_model[$];
  logic [MW-1:0] cur_meta;
  bit            cur_drop, in_pkt, exp_ovf, rand_done;
  int            tests, fails;
  int            s_acc_cnt, mvalid_cnt, mirror_bad, exp_pass, exp_drop;

  // Observe outputs on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_if.tvalid) begin
        mvalid_cnt++;
        if (m_if.tready !== s_if.tready) mirror_bad++;
      end
      if (m_if.tvalid && m_if.tready) begin
        mon_b.data  = m_if.tdata;
        mon_b.keep  = m_if.tkeep;
        mon_b.user  = m_if.tuser;
        mon_b.last  = m_if.tlast;
        mon_b.first = m_tfirst;
        mon_b.meta  = m_tmeta;
        got_q.push_back(mon_b);
      end
      if (s_if.tvalid && s_if.tready) s_acc_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] rand_meta(input bit drop);
    logic [MW-1:0] m;
    m    = MW'({$urandom, $urandom});
    m[0] = drop;
    return m;
  endfunction

  task automatic push_meta(input logic [MW-1:0] v);
    int g;
    bit ok;
    g = 0;
    ok = 1'b0;
    s_meta_valid = 1'b1;
    s_meta_info  = v;
    while (!ok && g < 300) begin
      @(negedge clk);
      ok = s_meta_ready;
      tick();
      g++;
    end
    s_meta_valid = 1'b0;
    chk("meta_push_handshake", ok, 1);
    if (ok) meta_model.push_back(v);
  endtask

  // Sends beats [start, stop) of a packet of 'total' beats; the model pairs each new packet
  // with the oldest outstanding metadata and decides forward/discard from bit 0.
  task automatic send_beats(input int start, input int stop, input int total);
    for (int b = start; b < stop; b++) begin
      int    g;
      bit    ok;
      beat_t e;
      g  = 0;
      ok = 1'b0;
      s_if.tdata  = {$urandom, $urandom};
      s_if.tkeep  = KW'($urandom);
      s_if.tuser  = UW'($urandom);
      s_if.tlast  = (b == total - 1);
      s_if.tvalid = 1'b1;
      while (!ok && g < 500) begin
        @(negedge clk);
        ok = s_if.tready;
        tick();
        g++;
      end
      chk("beat_handshake", ok, 1);
      if (ok) begin
        e.first = !in_pkt;
        if (!in_pkt) begin
          cur_meta = (meta_model.size() > 0) ? meta_model.pop_front() : '0;
          cur_drop = cur_meta[0];
        end
        if (!cur_drop) begin
          e.data = s_if.tdata;
          e.keep = s_if.tkeep;
          e.user = s_if.tuser;
          e.last = s_if.tlast;
          e.meta = cur_meta;
          exp_q.push_back(e);
        end
        in_pkt = !s_if.tlast;
        if (s_if.tlast) begin
          if (cur_drop) exp_drop++;
          else          exp_pass++;
        end
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic check_stats(input string tag);
    chk({tag, "_stat_pass"}, st_pass, StatsOn ? exp_pass : 0);
    chk({tag, "_stat_drop"}, st_drop, StatsOn ? exp_drop : 0);
    chk({tag, "_stat_ovf"}, st_ovf, StatsOn ? exp_ovf : 1'b0);
  endtask

  task automatic check_out(input string tag);
    int g;
    int n;
    g = 0;
    while (got_q.size() < exp_q.size() && g < 300) begin
      tick();
      g++;
    end
    repeat (3) tick();
    chk({tag, "_nbeats"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_beat"}, got_q[i], exp_q[i]);
    check_stats(tag);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_tready"}, s_if.tready, 0);
    chk({tag, "_m_tvalid"}, m_if.tvalid, 0);
    chk({tag, "_m_tfirst"}, m_tfirst, 0);
    chk({tag, "_m_tmeta"}, m_tmeta, 0);
    chk({tag, "_s_meta_ready"}, s_meta_ready, 1);
    chk({tag, "_stat_pass"}, st_pass, 0);
    chk({tag, "_stat_drop"}, st_drop, 0);
    chk({tag, "_stat_ovf"}, st_ovf, 0);
  endtask

  initial begin
    logic [3:0] pat;
    int         s0, mv0, len, dly;
    bit         drop;

    tests = 0; fails = 0; s_acc_cnt = 0; mvalid_cnt = 0; mirror_bad = 0;
    exp_pass = 0; exp_drop = 0; exp_ovf = 0; in_pkt = 0; cur_drop = 0; cur_meta = '0;
    rst = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    m_if.tready = 1'b1;
    s_meta_valid = 1'b0; s_meta_info = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Metadata arrives 5 cycles after the payload is presented.
    fork
      send_beats(0, 3, 3);
      begin
        repeat (5) tick();
        chk("s1_no_early_handshake", s_acc_cnt, 0);
        push_meta(rand_meta(1'b0));
      end
    join
    check_out("s1");

    // Dropped packet: consumed silently.
    mv0 = mvalid_cnt;
    s0  = s_acc_cnt;
    push_meta(rand_meta(1'b1));
    send_beats(0, 4, 4);
    chk("s2_mvalid_low", mvalid_cnt - mv0, 0);
    chk("s2_beats_accepted", s_acc_cnt - s0, 4);
    check_out("s2");

    // Fill FIFO, overflow offer, then drain in order.
    for (int i = 0; i < DEPTH; i++) push_meta(rand_meta(1'b0));
    chk("s3_full_ready", s_meta_ready, 0);
    s_meta_valid = 1'b1;
    s_meta_info  = rand_meta(1'b0);
    tick();
    s_meta_valid = 1'b0;
    exp_ovf = 1'b1;
    chk("s3_ovf", st_ovf, StatsOn);
    for (int i = 0; i < DEPTH; i++) send_beats(0, 1, 1);
    check_out("s3");

    // Backpressure pattern 1,0,0,1 on the output.
    pat = 4'b1001;
    mirror_bad = 0;
    push_meta(rand_meta(1'b0));
    fork
      send_beats(0, 5, 5);
      begin
        for (int i = 0; i < 20; i++) begin
          m_if.tready = pat[i % 4];
          tick();
        end
        m_if.tready = 1'b1;
      end
    join
    chk("s4_ready_mirror", mirror_bad, 0);
    check_out("s4");

    // Randomized packets, metadata delays, drop bits and backpressure.
    rand_done = 1'b0;
    fork
      begin
        while (!rand_done) begin
          m_if.tready = 1'($urandom_range(0, 1));
          tick();
        end
      end
      begin
        for (int p = 0; p < 12; p++) begin
          drop = ($urandom_range(0, 3) == 0);
          len  = $urandom_range(1, 4);
          dly  = $urandom_range(0, 3);
          fork
            begin
              repeat (dly) tick();
              push_meta(rand_meta(drop));
            end
            send_beats(0, len, len);
          join
        end
        rand_done = 1'b1;
      end
    join
    m_if.tready = 1'b1;
    chk("rand_ready_mirror", mirror_bad, 0);
    check_out("rand");

    // Reset in the middle of a packet with entries still queued.
    for (int i = 0; i < 4; i++) push_meta(rand_meta(1'b0));
    send_beats(0, 2, 4);
    check_out("s5_pre");
    rst = 1'b1;
    repeat (2) tick();
    check_reset_outputs("s5_rst");
    meta_model.delete();
    in_pkt = 0; exp_pass = 0; exp_drop = 0; exp_ovf = 0;
    rst = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tlast  = 1'b0;
    s0 = s_acc_cnt;
    repeat (6) tick();
    chk("s5_fifo_empty_stall", s_acc_cnt - s0, 0);
    chk("s5_idle_tready", s_if.tready, 0);
    fork
      send_beats(2, 4, 4);
      push_meta(rand_meta(1'b0));
    join
    check_out("s5_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rbt_s_parser_sync.md
Name: rbt_s_parser_sync

Overview:
Rejoins the parser's payload stream with its packet-metadata stream. The parser top forwards payload untouched, while metadata arrives several cycles later from the stage chain. This block queues metadata in a parametrised FIFO and stalls payload until that packet's metadata is available. It then emits the packet with the metadata held on a sideband for every beat, or discards the whole packet when the metadata drop bit is set. It sits directly after the parser top, ahead of the match/action stages.

Parameters:
DATA_WIDTH, 512, AXIS data width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep width; KEEP_WIDTH*8 must equal DATA_WIDTH (elaboration error otherwise)
USER_WIDTH, 64, tuser width
PKT_METADATA_WIDTH, 274, metadata width
META_FIFO_DEPTH, 16, metadata FIFO entries; power of 2, at least 2
DROP_BIT_INDEX, 0, metadata bit that marks the packet for discard

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_WIDTH  payload in
s_axis_tkeep  in  KEEP_WIDTH
s_axis_tvalid  in  1
s_axis_tready  out  1
s_axis_tlast  in  1
s_axis_tuser  in  USER_WIDTH
s_meta_valid  in  1  metadata in
s_meta_ready  out  1
s_meta_info  in  PKT_METADATA_WIDTH
m_axis_tdata  out  DATA_WIDTH  payload out
m_axis_tkeep  out  KEEP_WIDTH
m_axis_tvalid  out  1
m_axis_tready  in  1
m_axis_tlast  out  1
m_axis_tuser  out  USER_WIDTH
m_axis_tfirst  out  1  high on the first beat of each packet
m_axis_tmeta  out  PKT_METADATA_WIDTH  metadata of the current packet, stable for the whole packet
stat_pkt_pass  out  32  forwarded-packet count
stat_pkt_drop  out  32  dropped-packet count
stat_meta_ovf  out  1  sticky: metadata offered while the FIFO was full

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; FIFO empty (read and write pointers 0, count 0); s_axis_tready=0; m_axis_tvalid=0; m_axis_tfirst=0; m_axis_tmeta=0; all stats 0.
- Metadata FIFO:
  - s_meta_ready = !full.
  - Push on s_meta_valid && s_meta_ready.
  - A pop in the same cycle does not free a slot for the push in that cycle.
  - Count width is log2(DEPTH)+1; pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
- State machine states: IDLE, PASS, DROP.
- IDLE:
  - s_axis_tready=0.
  - When FIFO is not empty and s_axis_tvalid=1: pop the head, register it into m_axis_tmeta, set first_flag=1.
  - Go to DROP if head[DROP_BIT_INDEX]=1, otherwise PASS.
  - Transition takes 1 cycle. No payload beat is consumed in the transition cycle.
- PASS:
  - m_axis_tvalid = s_axis_tvalid.
  - s_axis_tready = m_axis_tready.
  - data, keep, last and user are combinational passthrough.
  - m_axis_tfirst = first_flag. first_flag clears on the first accepted beat.
  - On an accepted beat with tlast: stat_pkt_pass += 1, go to IDLE.
- DROP:
  - s_axis_tready=1; m_axis_tvalid=0.
  - On an accepted beat with tlast: stat_pkt_drop += 1, go to IDLE.
- Back-to-back packets: minimum 1 IDLE cycle between packets (one bubble).
- Single-beat packet (first beat carries tlast): tfirst and tlast are both high on that beat.
- Empty FIFO with payload waiting: payload stalls indefinitely; no timeout.
- Counters wrap from 2^32-1 to 0.
- stat_meta_ovf sets when s_meta_valid=1 while full; it clears only on rst.
- m_axis_tmeta holds its value through IDLE until the next pop.
- Reset mid-packet: state goes to IDLE and the FIFO is flushed. Leftover beats of the interrupted packet are treated as a new packet and pair with the next metadata to arrive.

Optional Feature:
RBT_S_SYNC_STATS_EN
- Defined: stat_pkt_pass, stat_pkt_drop and stat_meta_ovf behave as above.
- Undefined: counter and sticky logic is not compiled; all three stat outputs are tied to 0. Datapath behaviour is identical in both cases.

Test Plan:
- Metadata with drop bit=0 pushed 5 cycles after a 3-beat packet is presented -> no s_axis handshake before the pop; 3 output beats; tfirst only on beat 0; tlast on beat 2; m_axis_tmeta equals the pushed value on all beats; stat_pkt_pass=1.
- Metadata with bit DROP_BIT_INDEX=1 plus a 4-beat packet -> m_axis_tvalid stays 0; all 4 beats accepted; stat_pkt_drop=1.
- Push 16 metadata entries (DEPTH=16) with no payload -> s_meta_ready=0 after the 16th push; 17th offer sets stat_meta_ovf=1; then 16 single-beat packets drain in FIFO order with the correct tmeta each.
- m_axis_tready toggling 1,0,0,1 during a 5-beat PASS -> no beat lost or duplicated; s_axis_tready mirrors m_axis_tready.
- rst asserted on beat 2 of a 4-beat packet with 3 entries queued -> after reset the FIFO count is 0 and the state is IDLE; all outputs at reset values.
- Build without RBT_S_SYNC_STATS_EN, run scenario 1 -> identical datapath output; stat outputs remain 0.
